// File: rtl/bar_buf_pkg.sv
// bar_buf_pkg: shared sizes and control-bit indices for the bar height buffer
package bar_buf_pkg;
  localparam int NUM_BARS = 32;
  localparam int DATA_W = 6;
  localparam int ADDR_W = $clog2(NUM_BARS);
  localparam int CTRL_WR = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_CLR = 2;
endpackage

// File: rtl/bar_height_dpram.sv
// bar_height_dpram: simple dual-port RAM, synchronous write, registered read
module bar_height_dpram #(
  parameter int DEPTH = 64,
  parameter int W = 6,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  // only the output register is reset; the array stays a plain block RAM
  always_ff @(posedge clk)
    rd_data <= reset ? '0 : mem[rd_addr];
endmodule

// File: rtl/bar_height_buffer.sv
// bar_height_buffer: double-buffered bar heights, bank swap on commit at frame start
module bar_height_buffer
  import bar_buf_pkg::*;
#(
  parameter int NUM_BARS = bar_buf_pkg::NUM_BARS,
  parameter int DATA_W = bar_buf_pkg::DATA_W,
  parameter int ADDR_W = bar_buf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [2:0]        ram_ctrl,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              commit_pending,
  output logic              drop_err,
  output logic              front_bank
);
  logic [1:0] ctrl_q;
  logic wr_edge, commit_edge, clr, do_wr, drop, swap;
  assign wr_edge = ram_ctrl[CTRL_WR] & ~ctrl_q[CTRL_WR];
  assign commit_edge = ram_ctrl[CTRL_COMMIT] & ~ctrl_q[CTRL_COMMIT];
  assign clr = ram_ctrl[CTRL_CLR];
  assign do_wr = wr_edge & ~commit_pending & ~clr & ~reset;
  assign drop = wr_edge & commit_pending;
  assign swap = frame_start & commit_pending;
  // ctrl_q tracks the live strobes during reset so a level held across release is not an edge
  always_ff @(posedge clk) begin
    ctrl_q <= ram_ctrl[1:0];
    if (reset) begin
      wr_ptr <= '0;
      commit_pending <= 1'b0;
      drop_err <= 1'b0;
      front_bank <= 1'b0;
    end else begin
      wr_ptr <= (swap || clr) ? '0 : do_wr ? wr_ptr + 1'b1 : wr_ptr;
      commit_pending <= swap ? 1'b0 : commit_edge ? 1'b1 : commit_pending;
      drop_err <= swap ? 1'b0 : drop ? 1'b1 : drop_err;
      front_bank <= front_bank ^ swap;
    end
  end
  bar_height_dpram #(.DEPTH(2 * NUM_BARS), .W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk(clk),
    .reset(reset),
    .we(do_wr),
    .wr_addr({~front_bank, wr_ptr}),
    .wr_data(ram_data),
    .rd_addr({front_bank, rd_addr}),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_bar_height_buffer.sv
// tb_bar_height_buffer: table-driven and directed checks of the bar height buffer
module tb_bar_height_buffer;
  logic clk = 0, reset = 1, frame_start = 0;
  logic [5:0] ram_data = 0;
  logic [2:0] ram_ctrl = 0;
  logic [4:0] rd_addr = 0;
  logic [5:0] rd_data;
  logic [4:0] wr_ptr;
  logic commit_pending, drop_err, front_bank;
  int total = 0, bad = 0;
  typedef enum {OP_WR, OP_COMMIT, OP_FRAME, OP_CLR, OP_RD, OP_FC, OP_WC, OP_FW} op_t;
  typedef struct {
    op_t op;
    logic [5:0] d;
    logic [4:0] ptr;
    logic pend, front, drop;
    logic [5:0] rd;
  } vec_t;
  vec_t tv [18];
  always #5 clk = ~clk;
  bar_height_buffer dut (
    .clk(clk), .reset(reset), .ram_data(ram_data), .ram_ctrl(ram_ctrl),
    .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_ptr(wr_ptr), .commit_pending(commit_pending), .drop_err(drop_err),
    .front_bank(front_bank)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic status(input string name, input logic [4:0] p, input logic pe, input logic fr, input logic dr);
    chk({name, ".wr_ptr"}, 32'(wr_ptr), 32'(p));
    chk({name, ".pending"}, 32'(commit_pending), 32'(pe));
    chk({name, ".front"}, 32'(front_bank), 32'(fr));
    chk({name, ".drop"}, 32'(drop_err), 32'(dr));
  endtask
  task automatic pulse(input logic [2:0] c, input logic f, input logic [5:0] d);
    ram_data = d;
    ram_ctrl = c;
    frame_start = f;
    tick();
    ram_ctrl = 0;
    frame_start = 0;
    tick();
  endtask
  task automatic rd(input logic [4:0] a, input logic [5:0] exp, input string name);
    rd_addr = a;
    tick();
    chk(name, 32'(rd_data), 32'(exp));
  endtask
  initial begin
    tv[0]  = '{OP_WR,     6'd7,    5'd1, 1'b0, 1'b1, 1'b0, 6'd0};
    tv[1]  = '{OP_WR,     6'd9,    5'd2, 1'b0, 1'b1, 1'b0, 6'd0};
    tv[2]  = '{OP_CLR,    6'd0,    5'd0, 1'b0, 1'b1, 1'b0, 6'd0};
    tv[3]  = '{OP_WR,     6'd11,   5'd1, 1'b0, 1'b1, 1'b0, 6'd0};
    tv[4]  = '{OP_COMMIT, 6'd0,    5'd1, 1'b1, 1'b1, 1'b0, 6'd0};
    tv[5]  = '{OP_WR,     6'h2A,   5'd1, 1'b1, 1'b1, 1'b1, 6'd0};
    tv[6]  = '{OP_FRAME,  6'd0,    5'd0, 1'b0, 1'b0, 1'b0, 6'd0};
    tv[7]  = '{OP_RD,     6'd0,    5'd0, 1'b0, 1'b0, 1'b0, 6'd11};
    tv[8]  = '{OP_RD,     6'd1,    5'd0, 1'b0, 1'b0, 1'b0, 6'd9};
    tv[9]  = '{OP_WC,     6'd3,    5'd1, 1'b1, 1'b0, 1'b0, 6'd0};
    tv[10] = '{OP_FW,     6'h2A,   5'd0, 1'b0, 1'b1, 1'b0, 6'd0};
    tv[11] = '{OP_RD,     6'd0,    5'd0, 1'b0, 1'b1, 1'b0, 6'd3};
    tv[12] = '{OP_RD,     6'd1,    5'd0, 1'b0, 1'b1, 1'b0, 6'd1};
    tv[13] = '{OP_RD,     6'd31,   5'd0, 1'b0, 1'b1, 1'b0, 6'd31};
    tv[14] = '{OP_FC,     6'd0,    5'd0, 1'b1, 1'b1, 1'b0, 6'd0};
    tv[15] = '{OP_FRAME,  6'd0,    5'd0, 1'b0, 1'b0, 1'b0, 6'd0};
    tv[16] = '{OP_FRAME,  6'd0,    5'd0, 1'b0, 1'b0, 1'b0, 6'd0};
    tv[17] = '{OP_RD,     6'd0,    5'd0, 1'b0, 1'b0, 1'b0, 6'd11};
    // strobes held high across reset release must not register as edges
    ram_ctrl = 3'b011;
    ram_data = 6'h15;
    tick();
    tick();
    status("reset", 5'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.rd_data", 32'(rd_data), 32'd0);
    reset = 0;
    tick();
    tick();
    ram_ctrl = 0;
    tick();
    status("no_spurious", 5'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) pulse(3'b001, 1'b0, 6'(k));
    chk("fill.wr_ptr", 32'(wr_ptr), 32'd0);
    pulse(3'b010, 1'b0, 6'd0);
    chk("fill.pending", 32'(commit_pending), 32'd1);
    pulse(3'b000, 1'b1, 6'd0);
    status("fill_swap", 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) rd(5'(k), 6'(k), $sformatf("readback[%0d]", k));
    for (int i = 0; i < 18; i++) begin
      case (tv[i].op)
        OP_WR:     pulse(3'b001, 1'b0, tv[i].d);
        OP_COMMIT: pulse(3'b010, 1'b0, tv[i].d);
        OP_FRAME:  pulse(3'b000, 1'b1, tv[i].d);
        OP_CLR:    pulse(3'b100, 1'b0, tv[i].d);
        OP_FC:     pulse(3'b010, 1'b1, tv[i].d);
        OP_WC:     pulse(3'b011, 1'b0, tv[i].d);
        OP_FW:     pulse(3'b001, 1'b1, tv[i].d);
        default:   rd(5'(tv[i].d), tv[i].rd, $sformatf("vec%0d.rd_data", i));
      endcase
      status($sformatf("vec%0d", i), tv[i].ptr, tv[i].pend, tv[i].front, tv[i].drop);
    end
    for (int i = 0; i < 33; i++) pulse(3'b001, 1'b0, 6'(i + 5));
    chk("wrap.wr_ptr", 32'(wr_ptr), 32'd1);
    pulse(3'b010, 1'b0, 6'd0);
    pulse(3'b000, 1'b1, 6'd0);
    status("wrap_swap", 5'd0, 1'b0, 1'b1, 1'b0);
    rd(5'd0, 6'd37, "wrap.idx0");
    rd(5'd1, 6'd6, "wrap.idx1");
    rd(5'd31, 6'd36, "wrap.idx31");
    for (int i = 0; i < 10; i++) pulse(3'b001, 1'b0, 6'(i));
    pulse(3'b010, 1'b0, 6'd0);
    status("pre_reset", 5'd10, 1'b1, 1'b1, 1'b0);
    reset = 1;
    tick();
    reset = 0;
    status("mid_reset", 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset.rd_data", 32'(rd_data), 32'd0);
    pulse(3'b000, 1'b1, 6'd0);
    status("post_reset_frame", 5'd0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bar_height_buffer.md
# bar_height_buffer

Double-buffered bar-height store between the Nios II PIO outputs and the VGA bar renderer. Software places a 6-bit height on the ram_data PIO and pulses a control PIO bit. The block then writes the height into the back bank at an auto-incrementing index. A commit request swaps banks at the next frame start, so the renderer never sees a half-written spectrum.

## Interface
Parameters:
- NUM_BARS, 32, number of bars per bank; must be a power of two.
- DATA_W, 6, bar height width; matches the ram_data PIO width.
- ADDR_W, 5, log2(NUM_BARS).

Ports:
- clk  in  1  single system clock, shared by the Nios subsystem and the renderer.
- reset  in  1  synchronous, active-high reset.
- ram_data  in  DATA_W  height value from the ram_data PIO out_port.
- ram_ctrl  in  3  control PIO levels:
  - bit0 = write strobe.
  - bit1 = commit request.
  - bit2 = pointer clear.
- frame_start  in  1  one-cycle pulse from the renderer at vertical blank.
- rd_addr  in  ADDR_W  renderer bar index.
- rd_data  out  DATA_W  height of bar rd_addr from the front bank.
- wr_ptr  out  ADDR_W  next back-bank write index, for a status PIO.
- commit_pending  out  1  commit accepted, swap not yet done.
- drop_err  out  1  sticky flag: a write was dropped.
- front_bank  out  1  bank currently being displayed.

## Operation
- Edge detection:
  - ram_ctrl[1:0] are registered each cycle into ctrl_q.
  - During reset, ctrl_q loads the live ram_ctrl value, so a bit already high at reset release creates no edge.
  - wr_edge = ram_ctrl[0] & ~ctrl_q[0].
  - commit_edge = ram_ctrl[1] & ~ctrl_q[1].
- Write, when wr_edge fires and commit_pending = 0:
  - ram_data is written to RAM at {~front_bank, wr_ptr}.
  - wr_ptr increments modulo NUM_BARS; 31 wraps to 0 silently.
- Write, when wr_edge fires and commit_pending = 1: the write is dropped, wr_ptr is held, and drop_err is set.
- Commit, when commit_edge fires and commit_pending = 0: commit_pending is set.
- Commit, when commit_edge fires and commit_pending = 1: no effect.
- Swap, when frame_start fires and commit_pending was already 1 at the start of that cycle:
  - front_bank toggles.
  - commit_pending clears.
  - wr_ptr returns to 0.
  - drop_err clears.
- Pointer clear: ram_ctrl[2] is level-sensitive. While it is high, wr_ptr = 0 and writes are suppressed. It does not affect commit_pending.
- Simultaneous events, same cycle:
  - wr_edge with commit_edge: the write completes into the back bank, then commit_pending is set.
  - frame_start with commit_edge, pending = 0: no swap; pending is set; the swap happens at the next frame_start.
  - frame_start with wr_edge, pending = 1: the write is dropped (drop_err set), then the swap clears drop_err. The net result is drop_err = 0 and the write is lost.
- Reset values:
  - front_bank = 0, wr_ptr = 0, commit_pending = 0, drop_err = 0, rd_data = 0.
  - RAM contents are not cleared; they are undefined until written.
- Reset asserted mid-operation: all pending state is abandoned on the next clk edge.

## Timing
- Write latency: with the wr_edge in cycle N, the RAM word and wr_ptr are updated at the clk edge ending cycle N. wr_ptr reads the new value in cycle N+1.
- Read latency:
  - rd_data is registered: rd_addr presented in cycle N gives rd_data valid in cycle N+1.
  - The read always uses the front_bank value of cycle N.
- Swap: with frame_start in cycle N, front_bank changes in N+1. Reads issued in N+1 return the new bank at N+2.
- Minimum strobe spacing: one cycle low between write pulses. Software PIO rates are far below this, so no back-pressure is provided.
- Read/write collision: the RAM is never read and written at the same address in the same cycle, because the write bank is always ~front_bank.

## Structure
- The package bar_buf_pkg holds:
  - NUM_BARS, DATA_W, ADDR_W.
  - The control bit indices CTRL_WR = 0, CTRL_COMMIT = 1, CTRL_CLR = 2.
- Sub-module bar_height_dpram:
  - Simple dual-port RAM of 2*NUM_BARS words × DATA_W.
  - One synchronous write port and one registered read port.
  - Infers block RAM; no reset on the array.
- The top level holds the edge detector, the wr_ptr counter, the commit/bank control and the status flags.

## Test plan
- Fill and readback:
  - Stimulus: reset, then 32 write pulses with heights 0..31, commit, then a frame_start pulse.
  - Required: front_bank = 1, commit_pending = 0, wr_ptr = 0; rd_addr k returns k one cycle later for every k.
- Spurious edge at reset: hold ram_ctrl = 3'b011 through reset and release it → no write, commit_pending = 0, wr_ptr = 0.
- Drop while pending:
  - Stimulus: commit, then a write of 6'h2A before frame_start.
  - Required: drop_err = 1 and wr_ptr unchanged.
  - After frame_start: drop_err = 0, and 2A is absent from both banks.
- Wrap:
  - Stimulus: 33 writes with no commit.
  - Required: wr_ptr = 1, and back-bank index 0 holds the 33rd value.
- Coincident frame_start and commit_edge with pending = 0: no swap that frame; swap at the next frame_start; front_bank toggles exactly once.
- Mid-operation reset:
  - Stimulus: reset after 10 writes and a pending commit.
  - Required: all outputs return to reset values; a subsequent frame_start causes no swap.
